// File: rtl/spindash_pkg.sv
// Shared types and default timing for the spindash YM2612 command path.
// Timing values are in clk_jt cycles.
package spindash_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int SETUP_DEF      = 2;
  localparam int WR_PULSE_DEF   = 12;
  localparam int ADDR_WAIT_DEF  = 102;
  localparam int DATA_WAIT_DEF  = 498;
  localparam int CNT_W          = 16;

  typedef struct packed {
    logic [4:0] chip;
    logic       port;
    logic [7:0] rnum;
    logic [7:0] data;
  } ym_cmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SETUP,
    S_A_STROBE,
    S_A_HOLD,
    S_A_WAIT,
    S_D_SETUP,
    S_D_STROBE,
    S_D_HOLD,
    S_D_WAIT
  } ym_state_t;

endpackage

// File: rtl/spindash_cmd_fifo.sv
// Command FIFO: registered pointers, level count, flush.
// Flush wins over a same-cycle push.
module spindash_cmd_fifo
  import spindash_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  ym_cmd_t                  wdata,
  input  logic                     pop,
  input  logic                     flush,
  output ym_cmd_t                  rdata,
  output logic                     empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL = LW'(DEPTH);

  ym_cmd_t       mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   level_nx;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((level != FULL) || do_pop);
  assign rdata   = mem[rp];

  always_comb begin
    level_nx = level;
    if (flush)
      level_nx = '0;
    else if (do_push && !do_pop)
      level_nx = level + LW'(1);
    else if (do_pop && !do_push)
      level_nx = level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ready <= 1'b0;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (do_push) wp <= wp + AW'(1);
        if (do_pop)  rp <= rp + AW'(1);
      end
      level <= level_nx;
      ready <= (level_nx != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

endmodule

// File: rtl/ym_write_scheduler.sv
// Replays queued YM2612 register writes as paced address/data bus cycles.
// Bus outputs lag the FSM state by one cycle; all are registered.
module ym_write_scheduler
  import spindash_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SETUP      = SETUP_DEF,
  parameter int WR_PULSE   = WR_PULSE_DEF,
  parameter int ADDR_WAIT  = ADDR_WAIT_DEF,
  parameter int DATA_WAIT  = DATA_WAIT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [4:0]                    cmd_chip,
  input  logic                          cmd_port,
  input  logic [7:0]                    cmd_reg,
  input  logic [7:0]                    cmd_data,
  input  logic                          flush,
  output logic [4:0]                    cs,
  output logic [1:0]                    addr,
  output logic [7:0]                    din,
  output logic                          wr_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] C_AWAIT = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] C_DWAIT = CNT_W'(DATA_WAIT - 1);

  ym_state_t        state;
  logic [CNT_W-1:0] cnt;
  ym_cmd_t          cur;
  ym_cmd_t          head;
  ym_cmd_t          wdata;
  logic             empty;
  logic             push;
  logic             pop;
  logic             fin;

  assign wdata = '{chip: cmd_chip, port: cmd_port,
                   rnum: cmd_reg, data: cmd_data};
  assign push  = cmd_valid && cmd_ready;
  assign fin   = ((state == S_D_WAIT) && (cnt == '0)) ||
                 ((state == S_D_HOLD) && (DATA_WAIT == 0));
  assign pop   = !empty && ((state == S_IDLE) || fin);
  assign busy  = (state != S_IDLE) || !empty;

  spindash_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .empty (empty),
    .ready (cmd_ready),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      cur   <= '0;
      cs    <= '0;
      addr  <= '0;
      din   <= '0;
      wr_n  <= 1'b1;
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (pop) begin
        cur <= head;
        if (head.chip != '0) begin
          state <= S_A_SETUP;
          cnt   <= C_SETUP;
        end else begin
          state <= S_IDLE;
        end
      end else if (fin) begin
        state <= S_IDLE;
      end else if (cnt == '0) begin
        unique case (state)
          S_A_SETUP: begin
            state <= S_A_STROBE;
            cnt   <= C_PULSE;
          end
          S_A_STROBE: begin
            state <= S_A_HOLD;
            cnt   <= '0;
          end
          S_A_HOLD: begin
            if (ADDR_WAIT != 0) begin
              state <= S_A_WAIT;
              cnt   <= C_AWAIT;
            end else begin
              state <= S_D_SETUP;
              cnt   <= C_SETUP;
            end
          end
          S_A_WAIT: begin
            state <= S_D_SETUP;
            cnt   <= C_SETUP;
          end
          S_D_SETUP: begin
            state <= S_D_STROBE;
            cnt   <= C_PULSE;
          end
          S_D_STROBE: begin
            state <= S_D_HOLD;
            cnt   <= '0;
          end
          S_D_HOLD: begin
            state <= S_D_WAIT;
            cnt   <= C_DWAIT;
          end
          default: ;
        endcase
      end

      // cs only moves in SETUP/WAIT, never under a low wr_n
      unique case (state)
        S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
          cs   <= cur.chip;
          addr <= {cur.port, 1'b0};
          din  <= cur.rnum;
          wr_n <= (state != S_A_STROBE);
        end
        S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
          cs   <= cur.chip;
          addr <= {cur.port, 1'b1};
          din  <= cur.data;
          wr_n <= (state != S_D_STROBE);
        end
        default: begin
          cs   <= '0;
          wr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
